midi_msg_rx: RTL and testbench

- Parametrised MIDI input front end: oversampling UART receiver plus channel-voice message parser.
- Sits between the MIDI opto input pin and the note display/synth logic.
- Emits one-cycle note events (note number, velocity, channel) and a held-note indication.
- Adds programmable bit timing, framing-error detection, running status, real-time byte filtering, channel filtering and velocity-0 note-off over the previous receiver.

---
 rtl/midi_msg_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_midi_msg_rx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_rx.sv
// MIDI input front end: oversampling 8N1 receiver feeding a channel-voice
// note parser with running status, real-time filtering and held-note tracking.
module midi_msg_rx #(
    parameter int CLKS_PER_BIT = 128,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_in,
    input  logic [3:0] chan_sel,
    input  logic       omni,
    output logic       note_valid,
    output logic       note_on,
    output logic [6:0] note_num,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic       note_held,
    output logic [6:0] active_note,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_WAIT_NOTE,
        P_WAIT_VEL
    } p_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_t rx_state;
    rx_state_t rx_next;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          cyc_tick;
    logic          half_tick;
    logic          data_sample;
    logic          byte_strobe;
    logic          stop_bad;

    p_state_t   p_state;
    p_state_t   p_next;
    logic       rs_valid;
    logic       rs_kind;
    logic [3:0] rs_chan;
    logic [6:0] note_lat;
    logic       is_realtime;
    logic       is_system;
    logic       is_voice_ok;
    logic       rs_set;
    logic       rs_clr;
    logic       note_load;
    logic       ev_fire;
    logic       ev_on;

    // Synchroniser resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], midi_in};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    assign cyc_tick  = (cyc_cnt == BIT_LAST);
    assign half_tick = (cyc_cnt == HALF_LAST);

    always_comb begin
        rx_next     = rx_state;
        data_sample = 1'b0;
        byte_strobe = 1'b0;
        stop_bad    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (half_tick) begin
                    rx_next = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cyc_tick) begin
                    data_sample = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cyc_tick) begin
                    if (rxs) begin
                        byte_strobe = 1'b1;
                        rx_next     = RX_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        rx_next  = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rxs) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Cycle counter restarts on every state change so each phase times from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (rx_state == RX_IDLE || rx_state == RX_BREAK ||
                rx_next != rx_state || cyc_tick) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (rx_state == RX_START) begin
                bit_cnt <= '0;
            end else if (data_sample) begin
                bit_cnt   <= bit_cnt + 1'b1;
                shift_reg <= {rxs, shift_reg[7:1]};
            end
        end
    end

    assign is_realtime = (shift_reg[7:3] == 5'b11111);
    assign is_system   = (shift_reg[7:4] == 4'hF);
    assign is_voice_ok = (shift_reg[7:5] == 3'b100) &&
                         (omni || shift_reg[3:0] == chan_sel);
    assign ev_on       = rs_kind && (shift_reg[6:0] != 7'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state <= P_IDLE;
        end else begin
            p_state <= p_next;
        end
    end

    // Status bytes take priority over the current parse position, which is
    // what aborts a partial message.
    always_comb begin
        p_next    = p_state;
        rs_set    = 1'b0;
        rs_clr    = 1'b0;
        note_load = 1'b0;
        ev_fire   = 1'b0;
        if (byte_strobe && !is_realtime) begin
            if (is_system) begin
                rs_clr = 1'b1;
                p_next = P_IDLE;
            end else if (is_voice_ok) begin
                rs_set = 1'b1;
                p_next = P_WAIT_NOTE;
            end else if (shift_reg[7]) begin
                rs_clr = 1'b1;
                p_next = P_IDLE;
            end else begin
                case (p_state)
                    P_IDLE: begin
                        if (rs_valid) begin
                            note_load = 1'b1;
                            p_next    = P_WAIT_VEL;
                        end
                    end
                    P_WAIT_NOTE: begin
                        note_load = 1'b1;
                        p_next    = P_WAIT_VEL;
                    end
                    P_WAIT_VEL: begin
                        ev_fire = 1'b1;
                        p_next  = P_IDLE;
                    end
                    default: p_next = P_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_valid    <= 1'b0;
            rs_kind     <= 1'b0;
            rs_chan     <= '0;
            note_lat    <= '0;
            note_valid  <= 1'b0;
            note_on     <= 1'b0;
            note_num    <= '0;
            velocity    <= '0;
            channel     <= '0;
            note_held   <= 1'b0;
            active_note <= '0;
        end else begin
            note_valid <= ev_fire;
            if (rs_set) begin
                rs_valid <= 1'b1;
                rs_kind  <= shift_reg[4];
                rs_chan  <= shift_reg[3:0];
            end else if (rs_clr) begin
                rs_valid <= 1'b0;
            end
            if (note_load) begin
                note_lat <= shift_reg[6:0];
            end
            if (ev_fire) begin
                note_on  <= ev_on;
                note_num <= note_lat;
                velocity <= shift_reg[6:0];
                channel  <= rs_chan;
                if (ev_on) begin
                    note_held   <= 1'b1;
                    active_note <= note_lat;
                end else if (note_lat == active_note) begin
                    note_held <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_rx.sv
// Directed bench for midi_msg_rx: drives serial MIDI bytes and checks the
// decoded note events, held-note state and framing-error pulses.
module tb_midi_msg_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       midi_in = 1'b1;
    logic [3:0] chan_sel = 4'd0;
    logic       omni = 1'b0;
    logic       note_valid;
    logic       note_on;
    logic [6:0] note_num;
    logic [6:0] velocity;
    logic [3:0] channel;
    logic       note_held;
    logic [6:0] active_note;
    logic       frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int nv_count    = 0;
    int fe_count    = 0;

    midi_msg_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .midi_in    (midi_in),
        .chan_sel   (chan_sel),
        .omni       (omni),
        .note_valid (note_valid),
        .note_on    (note_on),
        .note_num   (note_num),
        .velocity   (velocity),
        .channel    (channel),
        .note_held  (note_held),
        .active_note(active_note),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (note_valid === 1'b1) nv_count++;
        if (frame_err === 1'b1) fe_count++;
    end

    task automatic drive_bit(input logic v);
        midi_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic settle();
        midi_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        midi_in = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({note_valid, note_on, note_num, velocity, channel, note_held, active_note, frame_err} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got %h want 0",
                     {note_valid, note_on, note_num, velocity, channel, note_held, active_note, frame_err});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_note_on();
        int nv0;
        nv0 = nv_count;
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL note_on_count got %0d want 1", nv_count - nv0);
        end
        vectors++;
        if ({note_on, note_num, velocity, channel} !== {1'b1, 7'h3C, 7'h64, 4'h0}) begin
            miscompares++;
            $display("[TB] FAIL note_on_fields got on=%b num=%h vel=%h ch=%h want on=1 num=3c vel=64 ch=0",
                     note_on, note_num, velocity, channel);
        end
        vectors++;
        if ({note_held, active_note} !== {1'b1, 7'h3C}) begin
            miscompares++;
            $display("[TB] FAIL note_on_held got held=%b act=%h want held=1 act=3c", note_held, active_note);
        end
    endtask

    task automatic test_running_status();
        int nv0;
        nv0 = nv_count;
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL rs_count got %0d want 1", nv_count - nv0);
        end
        vectors++;
        if ({note_on, note_num, velocity, note_held, active_note} !== {1'b0, 7'h40, 7'h00, 1'b1, 7'h3C}) begin
            miscompares++;
            $display("[TB] FAIL rs_other_off got on=%b num=%h vel=%h held=%b act=%h want on=0 num=40 vel=0 held=1 act=3c",
                     note_on, note_num, velocity, note_held, active_note);
        end
        nv0 = nv_count;
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL rs_match_count got %0d want 1", nv_count - nv0);
        end
        vectors++;
        if ({note_on, note_num, note_held} !== {1'b0, 7'h3C, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rs_match_off got on=%b num=%h held=%b want on=0 num=3c held=0",
                     note_on, note_num, note_held);
        end
    endtask

    task automatic test_channel_filter();
        int nv0;
        chan_sel = 4'd0;
        omni = 1'b0;
        nv0 = nv_count;
        send_byte(8'h93, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 0 || note_held !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL chan_reject got count=%0d held=%b want count=0 held=0", nv_count - nv0, note_held);
        end
        omni = 1'b1;
        nv0 = nv_count;
        send_byte(8'h93, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL omni_count got %0d want 1", nv_count - nv0);
        end
        vectors++;
        if ({note_on, note_num, velocity, channel, note_held} !== {1'b1, 7'h3C, 7'h64, 4'h3, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL omni_fields got on=%b num=%h vel=%h ch=%h held=%b want on=1 num=3c vel=64 ch=3 held=1",
                     note_on, note_num, velocity, channel, note_held);
        end
        omni = 1'b0;
    endtask

    task automatic test_realtime();
        int nv0;
        nv0 = nv_count;
        send_byte(8'h90, 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'h50, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL realtime_count got %0d want 1", nv_count - nv0);
        end
        vectors++;
        if ({note_on, note_num, velocity, channel} !== {1'b1, 7'h3C, 7'h50, 4'h0}) begin
            miscompares++;
            $display("[TB] FAIL realtime_fields got on=%b num=%h vel=%h ch=%h want on=1 num=3c vel=50 ch=0",
                     note_on, note_num, velocity, channel);
        end
    endtask

    task automatic test_note_off_abort();
        int nv0;
        nv0 = nv_count;
        send_byte(8'h90, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h40, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL abort_count got %0d want 1", nv_count - nv0);
        end
        vectors++;
        if ({note_on, note_num, velocity, note_held} !== {1'b0, 7'h3C, 7'h40, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL abort_fields got on=%b num=%h vel=%h held=%b want on=0 num=3c vel=40 held=0",
                     note_on, note_num, velocity, note_held);
        end
    endtask

    task automatic test_frame_err();
        int nv0;
        int fe0;
        nv0 = nv_count;
        fe0 = fe_count;
        send_byte(8'h90, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        vectors++;
        if (fe_count - fe0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL frame_err_count got %0d want 1", fe_count - fe0);
        end
        vectors++;
        if (nv_count - nv0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL frame_err_no_note got %0d want 0", nv_count - nv0);
        end
        nv0 = nv_count;
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 1 || {note_on, note_num, velocity, note_held} !== {1'b1, 7'h3C, 7'h64, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL after_break got count=%0d on=%b num=%h vel=%h held=%b want count=1 on=1 num=3c vel=64 held=1",
                     nv_count - nv0, note_on, note_num, velocity, note_held);
        end
    endtask

    task automatic test_glitch();
        int nv0;
        int fe0;
        nv0 = nv_count;
        fe0 = fe_count;
        midi_in = 1'b0;
        repeat (4) @(negedge clk);
        midi_in = 1'b1;
        repeat (12) @(negedge clk);
        send_byte(8'h90, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h21, 1'b1);
        settle();
        vectors++;
        if (fe_count - fe0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_frame_err got %0d want 0", fe_count - fe0);
        end
        vectors++;
        if (nv_count - nv0 !== 1 || {note_num, velocity, active_note} !== {7'h45, 7'h21, 7'h45}) begin
            miscompares++;
            $display("[TB] FAIL glitch_then_msg got count=%0d num=%h vel=%h act=%h want count=1 num=45 vel=21 act=45",
                     nv_count - nv0, note_num, velocity, active_note);
        end
    endtask

    task automatic test_reset_mid();
        int nv0;
        send_byte(8'h90, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        #1;
        vectors++;
        if ({note_valid, note_on, note_num, velocity, channel, note_held, active_note, frame_err} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_outputs got %h want 0",
                     {note_valid, note_on, note_num, velocity, channel, note_held, active_note, frame_err});
        end
        midi_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        nv0 = nv_count;
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        settle();
        vectors++;
        if (nv_count - nv0 !== 0 || note_held !== 1'b0 || note_num !== 7'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_drops_rs got count=%0d held=%b num=%h want count=0 held=0 num=00",
                     nv_count - nv0, note_held, note_num);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_note_on();
        test_running_status();
        test_channel_filter();
        test_realtime();
        test_note_off_abort();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
